// File: rtl/sort_result_collector.sv
// Collects one sorted frame of N IEEE-754 words from the sorter, checks ordering
// on the fly, and offers a registered random-access readback port.
module sort_result_collector #(
  parameter int N  = 8,
  parameter int W  = 32,
  parameter int AW = $clog2(N)
) (
  input  logic          clock,
  input  logic          rst,
  input  logic [W-1:0]  in_data,
  input  logic          in_valid,
  input  logic          clear,
  input  logic [AW-1:0] rd_addr,
  output logic [W-1:0]  rd_data,
  output logic          busy,
  output logic          done,
  output logic [AW:0]   count,
  output logic          order_err,
  output logic [AW-1:0] err_index,
  output logic          overrun
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] COLLECT = 2'd1;
  localparam logic [1:0] DONE    = 2'd2;

  // Maps a float to an unsigned key giving IEEE total order (-0 sorts below +0).
  function automatic logic [W-1:0] order_key(input logic [W-1:0] x);
    logic [W-1:0] sign_mask;
    sign_mask = {1'b1, {(W-1){1'b0}}};
    return x[W-1] ? ~x : (x ^ sign_mask);
  endfunction

  logic [1:0]   state_r;
  logic [W-1:0] prev_key_r;
  logic [W-1:0] mem_r [N];

  logic [W-1:0] in_key_s;
  logic         wr_en_s;
  logic         last_s;
  logic         rd_oob_s;

  assign in_key_s = order_key(in_data);
  assign wr_en_s  = !rst && !clear && in_valid && (state_r != DONE);
  assign last_s   = (count == (AW+1)'(N - 1));
  assign rd_oob_s = ({1'b0, rd_addr} >= (AW+1)'(N));

  // Capture buffer; never reset, so a partial or dropped frame leaves old words intact.
  always_ff @(posedge clock) begin
    if (wr_en_s) begin
      mem_r[count[AW-1:0]] <= in_data;
    end
  end

  // Registered readback; a same-edge write is seen only on the following read.
  always_ff @(posedge clock) begin
    if (rst) begin
      rd_data <= {W{1'b0}};
    end else if (rd_oob_s) begin
      rd_data <= {W{1'b0}};
    end else begin
      rd_data <= mem_r[rd_addr];
    end
  end

  // Frame FSM, counters and sticky status flags.
  always_ff @(posedge clock) begin
    if (rst || clear) begin
      state_r    <= IDLE;
      prev_key_r <= {W{1'b0}};
      busy       <= 1'b0;
      done       <= 1'b0;
      count      <= {(AW+1){1'b0}};
      order_err  <= 1'b0;
      err_index  <= {AW{1'b0}};
      overrun    <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (in_valid) begin
            prev_key_r <= in_key_s;
            count      <= (AW+1)'(1);
            busy       <= 1'b1;
            state_r    <= COLLECT;
          end
        end
        COLLECT: begin
          if (in_valid) begin
            // Only the first violation is recorded; its index is the pre-increment count.
            if ((in_key_s < prev_key_r) && !order_err) begin
              order_err <= 1'b1;
              err_index <= count[AW-1:0];
            end
            prev_key_r <= in_key_s;
            count      <= count + (AW+1)'(1);
            if (last_s) begin
              state_r <= DONE;
              busy    <= 1'b0;
              done    <= 1'b1;
            end
          end
        end
        DONE: begin
          if (in_valid) begin
            overrun <= 1'b1;
          end
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

endmodule
